primus_instruction_decode: RTL and testbench
============================================

# primus_instruction_decode

Instruction decode stage of the primus RV32I core, directly downstream of instruction fetch. Accepts instruction word plus PC/next-PC over a valid/ready handshake, decodes register addresses, immediate and control flags, and presents a registered decode bundle to the execute stage. A one-entry skid buffer keeps `in_ready_o` registered. `flush_i` discards in-flight decode contents on branch redirect.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard output and skid contents.
- `in_valid_i`  in  1  fetch presents an instruction.
- `in_ready_o`  out  1  decode can accept.
- `ir_i`  in  32  instruction word.
- `pc_i`, `npc_i`  in  32 each  instruction PC and PC+4.
- `out_valid_o`  out  1  decode bundle valid.
- `out_ready_i`  in  1  execute accepts the bundle.
- `pc_o`, `npc_o`  out  32 each  forwarded PC and next PC.
- `rs1_addr_o`, `rs2_addr_o`, `rd_addr_o`  out  5 each  register indices.
- `imm_o`  out  32  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type).
- `funct3_o`  out  3  `ir[14:12]`.
- `alu_op_o`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_IMM.
- `reg_write_o`, `mem_read_o`, `mem_write_o`, `branch_o`, `jal_o`, `jalr_o`, `auipc_o`, `system_o`, `muldiv_o`, `illegal_o`  out  1 each  control flags.

## Operation
- **Handshake.** Input transfer occurs when `in_valid_i && in_ready_o`. Output transfer occurs when `out_valid_o && out_ready_i`.
- **Decode.** Decode is combinational on `ir_i`. The result is written into the output register, or into the skid register when the output is held.
- **Storage.** The output register holds the current bundle. The skid register holds one extra bundle.
- **Accept path.**
  - Output empty, or output transferring this cycle: the accepted input loads the output register.
  - Otherwise: the accepted input loads the skid register.
- **Drain path.** Output transfers and the skid register is valid: skid moves to output.
- **Ready.** `in_ready_o = !skid_valid_q && !rst_i`.
- **Opcodes.**
  - LUI: `alu_op` 10.
  - AUIPC: `auipc_o`.
  - JAL, JALR: `reg_write_o` set.
  - BRANCH: funct3 ∈ {0,1,4,5,6,7}.
  - LOAD: funct3 ∈ {0,1,2,4,5}.
  - STORE: funct3 ∈ {0,1,2}.
  - OP-IMM: SLLI requires funct7=0; SRLI/SRAI require funct7 ∈ {0x00,0x20}.
  - OP: funct7 ∈ {0x00,0x20}; 0x20 is legal only for ADD→SUB and SRL→SRA.
  - MISC-MEM: decodes as NOP.
  - SYSTEM: `system_o` set only for ECALL (0x00000073) and EBREAK (0x00100073).
- **Illegal instructions.**
  - Trigger: `ir[1:0]≠2'b11`, an unknown opcode, or a bad funct field.
  - Response: `illegal_o`=1; `reg_write_o`, `mem_*`, `branch_o`, `jal_o`, `jalr_o` all forced 0.
  - The instruction still flows down the pipeline.
- **rd=x0.** `reg_write_o` stays as decoded; execute/writeback ignores x0.

## Timing
- **Latency.** An accepted instruction appears on `out_valid_o` the next cycle, given an empty pipeline. Throughput is one per cycle while `out_ready_i`=1.
- **Reset.** While `rst_i` is high at a clock edge:
  - `out_valid_o` and `skid_valid` are cleared.
  - All output payload registers are cleared to 0.
  - `in_ready_o` is 0 while `rst_i` is high and 1 the first cycle after deassertion.
  - Reset mid-transfer drops everything.
- **Stability.** The output bundle is held stable while `out_valid_o && !out_ready_i`.
- **Flush.**
  - `flush_i` at an edge clears `out_valid_o` and `skid_valid` next cycle.
  - An input handshaking in the flush cycle is discarded.
  - Flush has priority over accept and drain.
  - `rst_i` has priority over `flush_i`.
- **Full.** Output valid and skid valid together mean `in_ready_o`=0. Fetch must hold `ir_i`/`pc_i` stable until accepted.
- **Simultaneous drain and accept** with skid valid cannot occur, because `in_ready_o`=0.

## Configuration
- `PRIMUS_DECODE_M_EN` defined:
  - OP with funct7=0x01 is legal.
  - `muldiv_o`=1, `reg_write_o`=1.
  - `funct3_o` selects MUL..REMU; `alu_op_o`=0.
- `PRIMUS_DECODE_M_EN` undefined:
  - Such encodings set `illegal_o`=1.
  - `muldiv_o` is tied 0.

## Test plan
- **ADDI.**
  - Stimulus: `rst_i` deasserted, then `ir_i`=0xFFF10093 (addi x1,x2,-1), `pc_i`=0x100.
  - Required next cycle: `out_valid_o`=1, rs1=2, rd=1, `imm_o`=0xFFFFFFFF, `alu_op_o`=0, `reg_write_o`=1, `pc_o`=0x100.
- **Store.**
  - Stimulus: `ir_i`=0x00532423 (sw x5,8(x6)).
  - Required: rs1=6, rs2=5, `imm_o`=8, `mem_write_o`=1, `reg_write_o`=0, `funct3_o`=2.
- **Backpressure.**
  - Stimulus: hold `out_ready_i`=0 and send two instructions back-to-back.
  - Required: the first is held on the outputs, the second is in skid, and `in_ready_o`=0.
  - Then raise `out_ready_i`: both emerge in order on consecutive cycles and `in_ready_o` returns to 1.
- **Flush.**
  - Stimulus: both entries full, assert `flush_i` one cycle together with `in_valid_i`=1.
  - Required next cycle: `out_valid_o`=0, nothing emerges afterwards, `in_ready_o`=1.
- **Illegal.**
  - Stimulus: `ir_i`=0x00000000.
  - Required: `illegal_o`=1 and all write/memory/branch flags 0.
- **M extension.**
  - Stimulus: `ir_i`=0x022081B3 (mul x3,x1,x2).
  - Required with macro: `muldiv_o`=1, rd=3, `illegal_o`=0.
  - Required without macro: `illegal_o`=1, `reg_write_o`=0.

Source files
------------

// File: rtl/primus_instruction_decode.sv
// primus_instruction_decode: RV32I decode stage with registered output bundle and one-entry skid buffer.
// Ports: clk_i, rst_i (sync, active-high), flush_i (drop output and skid contents);
//        in_valid_i/in_ready_o handshake carrying ir_i, pc_i, npc_i;
//        out_valid_o/out_ready_i handshake carrying pc_o, npc_o, rs1/rs2/rd_addr_o, imm_o, funct3_o, alu_op_o
//        and the control flags reg_write/mem_read/mem_write/branch/jal/jalr/auipc/system/muldiv/illegal.
// Optional M-extension decode: define PRIMUS_DECODE_M_EN.
module primus_instruction_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     ir_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] npc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      funct3_o,
    output logic [3:0]      alu_op_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic            auipc_o,
    output logic            system_o,
    output logic            muldiv_o,
    output logic            illegal_o
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            auipc;
        logic            system;
        logic            muldiv;
        logic            illegal;
    } bundle_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  alu_base;
    logic        legal;
    bundle_t     dec;
    bundle_t     out_d, out_q, skid_d, skid_q;
    logic        out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    logic        accept, out_fire;

    assign opc   = ir_i[6:0];
    assign f3    = ir_i[14:12];
    assign f7    = ir_i[31:25];
    assign imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_b = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign imm_u = {ir_i[31:12], 12'b0};
    assign imm_j = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
    // funct3 -> ALU op shared by OP and OP-IMM; ir[30] picks SRA over SRL
    assign alu_base = f3 == 3'd0 ? 4'd0 : f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 :
                      f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? (ir_i[30] ? 4'd7 : 4'd6) : f3 == 3'd6 ? 4'd8 : 4'd9;

    always_comb begin
        dec        = '0;
        dec.pc     = pc_i;
        dec.npc    = npc_i;
        dec.rs1    = ir_i[19:15];
        dec.rs2    = ir_i[24:20];
        dec.rd     = ir_i[11:7];
        dec.funct3 = f3;
        legal      = 1'b1;
        case (opc)
            7'b0110111: begin dec.imm = imm_u; dec.alu_op = 4'd10; dec.reg_write = 1'b1; end
            7'b0010111: begin dec.imm = imm_u; dec.auipc = 1'b1; dec.reg_write = 1'b1; end
            7'b1101111: begin dec.imm = imm_j; dec.jal = 1'b1; dec.reg_write = 1'b1; end
            7'b1100111: begin dec.imm = imm_i; dec.jalr = 1'b1; dec.reg_write = 1'b1; end
            7'b1100011: begin dec.imm = imm_b; dec.branch = 1'b1; legal = f3 != 3'd2 && f3 != 3'd3; end
            7'b0000011: begin
                dec.imm       = imm_i;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                legal         = f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
            end
            7'b0100011: begin dec.imm = imm_s; dec.mem_write = 1'b1; legal = f3 < 3'd3; end
            7'b0010011: begin
                dec.imm       = imm_i;
                dec.alu_op    = alu_base;
                dec.reg_write = 1'b1;
                legal         = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            7'b0110011: begin
`ifdef PRIMUS_DECODE_M_EN
                if (f7 == 7'h01) begin
                    dec.muldiv    = 1'b1;
                    dec.reg_write = 1'b1;
                end else
`endif
                begin
                    dec.alu_op    = (f3 == 3'd0 && ir_i[30]) ? 4'd1 : alu_base;
                    dec.reg_write = 1'b1;
                    legal         = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                end
            end
            7'b0001111: legal = 1'b1;
            7'b1110011: begin
                dec.system = ir_i == 32'h0000_0073 || ir_i == 32'h0010_0073;
                legal      = dec.system;
            end
            default: legal = 1'b0;
        endcase
        // illegal instructions still flow, but with every side-effecting flag suppressed
        dec.illegal = !legal;
        if (!legal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jal       = 1'b0;
            dec.jalr      = 1'b0;
            dec.muldiv    = 1'b0;
        end
    end

    assign in_ready_o = !skid_valid_q && !rst_i;
    assign accept     = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_q && out_ready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_fire) begin
                out_valid_d  = skid_valid_q;
                out_d        = skid_valid_q ? skid_q : out_q;
                skid_valid_d = 1'b0;
            end
            // accept never coincides with a skid drain since in_ready_o is low while skid is valid
            if (accept) begin
                if (!out_valid_q || out_fire) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign pc_o        = out_q.pc;
    assign npc_o       = out_q.npc;
    assign rs1_addr_o  = out_q.rs1;
    assign rs2_addr_o  = out_q.rs2;
    assign rd_addr_o   = out_q.rd;
    assign imm_o       = out_q.imm;
    assign funct3_o    = out_q.funct3;
    assign alu_op_o    = out_q.alu_op;
    assign reg_write_o = out_q.reg_write;
    assign mem_read_o  = out_q.mem_read;
    assign mem_write_o = out_q.mem_write;
    assign branch_o    = out_q.branch;
    assign jal_o       = out_q.jal;
    assign jalr_o      = out_q.jalr;
    assign auipc_o     = out_q.auipc;
    assign system_o    = out_q.system;
    assign muldiv_o    = out_q.muldiv;
    assign illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_primus_instruction_decode.sv
// tb_primus_instruction_decode: directed scoreboard bench for primus_instruction_decode.
// Expected bundles are queued when an instruction handshakes and compared when the bundle leaves the stage.
module tb_primus_instruction_decode;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, in_valid_i, out_ready_i;
    logic [31:0] ir_i, pc_i, npc_i;
    logic        in_ready_o, out_valid_o;
    logic [31:0] pc_o, npc_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o;
    logic        auipc_o, system_o, muldiv_o, illegal_o;
    logic [9:0]  fl_o;

    primus_instruction_decode #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ir_i(ir_i), .pc_i(pc_i), .npc_i(npc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .npc_o(npc_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .imm_o(imm_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .auipc_o(auipc_o),
        .system_o(system_o), .muldiv_o(muldiv_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // flag order: reg_write mem_read mem_write branch jal jalr auipc system muldiv illegal
    assign fl_o = {reg_write_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o,
                   auipc_o, system_o, muldiv_o, illegal_o};

    // m selects which of {rs2, rd, imm, alu} are meaningful for the instruction
    typedef struct packed {
        logic [31:0] ir, pc, npc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [9:0]  fl;
        logic [3:0]  m;
    } exp_t;

    exp_t sb[$];
    exp_t cur, mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [31:0] ir, pc, input logic [4:0] rs1, rs2, rd,
                                input logic [31:0] imm, input logic [2:0] f3, input logic [3:0] alu,
                                input logic [9:0] fl, input logic [3:0] m);
        exp_t e;
        e.ir = ir; e.pc = pc; e.npc = pc + 32'd4; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.f3 = f3; e.alu = alu; e.fl = fl; e.m = m;
        return e;
    endfunction

    function automatic exp_t at(input exp_t e, input logic [31:0] pc);
        exp_t r;
        r = e; r.pc = pc; r.npc = pc + 32'd4;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half;
        @(negedge clk_i);
        if (in_valid_i && in_ready_o && !flush_i && !rst_i) sb.push_back(cur);
    endtask

    task automatic edge_;
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc;
        half();
        edge_();
    endtask

    task automatic send(input exp_t e);
        cur = e; ir_i = e.ir; pc_i = e.pc; npc_i = e.npc; in_valid_i = 1'b1;
        cyc();
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: got pc %h expected no output", pc_o);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pc", pc_o, mon_e.pc);
                chk("npc", npc_o, mon_e.npc);
                chk("rs1", rs1_addr_o, mon_e.rs1);
                if (mon_e.m[3]) chk("rs2", rs2_addr_o, mon_e.rs2);
                if (mon_e.m[2]) chk("rd", rd_addr_o, mon_e.rd);
                if (mon_e.m[1]) chk("imm", imm_o, mon_e.imm);
                if (mon_e.m[0]) chk("alu_op", alu_op_o, mon_e.alu);
                chk("funct3", funct3_o, mon_e.f3);
                chk("flags", fl_o, mon_e.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    exp_t addi, sw, ill, mul, sub, slli_bad, ecall, beq_bad, srai, lw, bne, lui, jal;

    initial begin
        addi     = mk(32'hFFF10093, 32'h100, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 3'd0, 4'd0, 10'h200, 4'b0111);
        sw       = mk(32'h00532423, 32'h104, 5'd6, 5'd5, 5'd0, 32'h8, 3'd2, 4'd0, 10'h080, 4'b1010);
        ill      = mk(32'h00000000, 32'h108, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'd0, 10'h001, 4'b1100);
`ifdef PRIMUS_DECODE_M_EN
        mul      = mk(32'h022081B3, 32'h10C, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'd0, 10'h202, 4'b1111);
`else
        mul      = mk(32'h022081B3, 32'h10C, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'd0, 10'h001, 4'b1110);
`endif
        sub      = mk(32'h402081B3, 32'h110, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'd1, 10'h200, 4'b1111);
        slli_bad = mk(32'h40009093, 32'h114, 5'd1, 5'd0, 5'd1, 32'h0, 3'd1, 4'd0, 10'h001, 4'b0100);
        ecall    = mk(32'h00000073, 32'h118, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'd0, 10'h004, 4'b0100);
        beq_bad  = mk(32'h00002063, 32'h11C, 5'd0, 5'd0, 5'd0, 32'h0, 3'd2, 4'd0, 10'h001, 4'b1000);
        srai     = mk(32'h40325213, 32'h120, 5'd4, 5'd0, 5'd4, 32'h403, 3'd5, 4'd7, 10'h200, 4'b0111);
        lw       = mk(32'hFFC12503, 32'h124, 5'd2, 5'd0, 5'd10, 32'hFFFFFFFC, 3'd2, 4'd0, 10'h300, 4'b0110);
        bne      = mk(32'hFE209EE3, 32'h128, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd1, 4'd0, 10'h040, 4'b1010);
        lui      = mk(32'h123452B7, 32'h200, 5'd8, 5'd0, 5'd5, 32'h12345000, 3'd5, 4'd10, 10'h200, 4'b0111);
        jal      = mk(32'h008000EF, 32'h204, 5'd0, 5'd0, 5'd1, 32'h8, 3'd0, 4'd0, 10'h220, 4'b0110);

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        ir_i = '0; pc_i = '0; npc_i = '0; cur = '0;
        cyc();
        half();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_flags", fl_o, 0);
        edge_();
        rst_i = 1'b0;
        half();
        chk("ready_after_rst", in_ready_o, 1);
        edge_();

        send(addi);
        in_valid_i = 1'b0;
        half();
        chk("lat_valid", out_valid_o, 1);
        chk("lat_pc", pc_o, 32'h100);
        edge_();

        send(sw); send(ill); send(mul); send(sub); send(slli_bad); send(ecall);
        send(beq_bad); send(srai); send(lw); send(bne);
        in_valid_i = 1'b0;
        repeat (3) cyc();
        chk("stream_drained", sb.size(), 0);

        out_ready_i = 1'b0;
        send(lui);
        send(jal);
        send(at(sub, 32'h300));
        half();
        chk("bp_in_ready", in_ready_o, 0);
        chk("bp_out_valid", out_valid_o, 1);
        chk("bp_pc_held", pc_o, 32'h200);
        chk("bp_imm_held", imm_o, 32'h12345000);
        edge_();
        out_ready_i = 1'b1;
        half();
        chk("bp_first_out", pc_o, 32'h200);
        chk("bp_still_full", in_ready_o, 0);
        edge_();
        half();
        chk("bp_second_out", pc_o, 32'h204);
        chk("bp_ready_back", in_ready_o, 1);
        edge_();
        in_valid_i = 1'b0;
        repeat (3) cyc();
        chk("bp_drained", sb.size(), 0);

        out_ready_i = 1'b0;
        send(at(addi, 32'h400));
        send(at(sw, 32'h404));
        cur = at(ill, 32'h408); ir_i = cur.ir; pc_i = cur.pc; npc_i = cur.npc;
        flush_i = 1'b1;
        half();
        chk("full_in_ready", in_ready_o, 0);
        sb.delete();
        edge_();
        flush_i = 1'b0; in_valid_i = 1'b0;
        half();
        chk("flush_out_valid", out_valid_o, 0);
        chk("flush_in_ready", in_ready_o, 1);
        edge_();
        out_ready_i = 1'b1;
        repeat (3) begin
            half();
            chk("flush_idle", out_valid_o, 0);
            edge_();
        end

        cur = at(sub, 32'h500); ir_i = cur.ir; pc_i = cur.pc; npc_i = cur.npc;
        in_valid_i = 1'b1; flush_i = 1'b1;
        half();
        chk("flush_hs_ready", in_ready_o, 1);
        edge_();
        flush_i = 1'b0; in_valid_i = 1'b0;
        half();
        chk("flush_hs_dropped", out_valid_o, 0);
        edge_();

        out_ready_i = 1'b0;
        send(at(sub, 32'h600));
        cur = at(sub, 32'h604); ir_i = cur.ir; pc_i = cur.pc; npc_i = cur.npc;
        rst_i = 1'b1;
        half();
        chk("rst_mid_ready", in_ready_o, 0);
        sb.delete();
        edge_();
        half();
        chk("rst_mid_valid", out_valid_o, 0);
        chk("rst_mid_pc", pc_o, 0);
        edge_();
        rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        half();
        chk("rst_mid_ready_back", in_ready_o, 1);
        edge_();
        repeat (2) cyc();

        chk("final_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
